ctrl_bubble_pipe: RTL and testbench

- Parametrised control-signal pipeline for the 5-stage CPU. Carries decoded EX/MEM/WB control bundles through the ID/EX, EX/MEM and MEM/WB registers.
- Generalises the combinational hazard mux that zeroes control signals on a stall. This block does the bubble insertion inside the registers, adds flush, adds a global freeze (hold) and per-stage valid bits, and keeps a saturating bubble counter for performance monitoring.
- Sits between the control unit/hazard detection unit and the datapath pipeline registers.

---
 rtl/ctrl_bubble_pipe.sv | 75 +++++++
 tb/tb_ctrl_bubble_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_bubble_pipe.sv
// Control-bundle pipeline (ID/EX -> EX/MEM -> MEM/WB) with bubble insertion,
// global freeze, per-stage valid bits and a saturating bubble counter.
module ctrl_bubble_pipe #(
    parameter int EX_W  = 2,
    parameter int MEM_W = 3,
    parameter int WB_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             freeze_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [EX_W-1:0]  ex_sig_i,
    input  logic [MEM_W-1:0] mem_sig_i,
    input  logic [WB_W-1:0]  wb_sig_i,
    input  logic             cnt_clr_i,
    output logic [EX_W-1:0]  idex_ex_o,
    output logic [MEM_W-1:0] idex_mem_o,
    output logic [WB_W-1:0]  idex_wb_o,
    output logic             idex_valid_o,
    output logic [MEM_W-1:0] exmem_mem_o,
    output logic [WB_W-1:0]  exmem_wb_o,
    output logic             exmem_valid_o,
    output logic [WB_W-1:0]  memwb_wb_o,
    output logic             memwb_valid_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // Valid semantics: a stage's valid bit is 1 only when it holds a real
    // instruction; whenever it is 0 the stage's bundles are all-zero, so a
    // consumer may act on the bundles without looking at valid.
    logic bubble;
    logic take;

    assign bubble = stall_i | flush_i;
    assign take   = valid_i & ~bubble;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ex_o     <= '0;
            idex_mem_o    <= '0;
            idex_wb_o     <= '0;
            idex_valid_o  <= 1'b0;
            exmem_mem_o   <= '0;
            exmem_wb_o    <= '0;
            exmem_valid_o <= 1'b0;
            memwb_wb_o    <= '0;
            memwb_valid_o <= 1'b0;
        end else if (!freeze_i) begin
            idex_ex_o     <= take ? ex_sig_i  : '0;
            idex_mem_o    <= take ? mem_sig_i : '0;
            idex_wb_o     <= take ? wb_sig_i  : '0;
            idex_valid_o  <= take;
            exmem_mem_o   <= idex_mem_o;
            exmem_wb_o    <= idex_wb_o;
            exmem_valid_o <= idex_valid_o;
            memwb_wb_o    <= exmem_wb_o;
            memwb_valid_o <= exmem_valid_o;
        end
    end

    // Clear beats both freeze and a same-edge bubble; the count never wraps.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bubble_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            bubble_cnt_o <= '0;
        end else if (!freeze_i && bubble && (bubble_cnt_o != {CNT_W{1'b1}})) begin
            bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_bubble_pipe.sv
// Bench for ctrl_bubble_pipe: directed vectors, per-stage expected queues
// popped by a monitor, plus a narrow-counter instance for saturation.
module tb_ctrl_bubble_pipe;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       freeze_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
    logic [1:0] ex_sig_i = '0;
    logic [2:0] mem_sig_i = '0;
    logic [1:0] wb_sig_i = '0;
    logic       cnt_clr_i = 1'b0;

    logic [1:0]  idex_ex_o, idex_wb_o, exmem_wb_o, memwb_wb_o;
    logic [2:0]  idex_mem_o, exmem_mem_o;
    logic        idex_valid_o, exmem_valid_o, memwb_valid_o;
    logic [15:0] bubble_cnt_o;

    logic [1:0] s_idex_ex, s_idex_wb, s_exmem_wb, s_memwb_wb;
    logic [2:0] s_idex_mem, s_exmem_mem;
    logic       s_idex_valid, s_exmem_valid, s_memwb_valid;
    logic [1:0] s_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    logic [1:0] exp_ex_q[$];
    logic [2:0] exp_mem_q[$];
    logic [1:0] exp_wb_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    ctrl_bubble_pipe dut (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_i(valid_i), .ex_sig_i(ex_sig_i),
        .mem_sig_i(mem_sig_i), .wb_sig_i(wb_sig_i), .cnt_clr_i(cnt_clr_i),
        .idex_ex_o(idex_ex_o), .idex_mem_o(idex_mem_o), .idex_wb_o(idex_wb_o),
        .idex_valid_o(idex_valid_o), .exmem_mem_o(exmem_mem_o),
        .exmem_wb_o(exmem_wb_o), .exmem_valid_o(exmem_valid_o),
        .memwb_wb_o(memwb_wb_o), .memwb_valid_o(memwb_valid_o),
        .bubble_cnt_o(bubble_cnt_o)
    );

    ctrl_bubble_pipe #(.CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .freeze_i(freeze_i), .stall_i(stall_i),
        .flush_i(flush_i), .valid_i(valid_i), .ex_sig_i(ex_sig_i),
        .mem_sig_i(mem_sig_i), .wb_sig_i(wb_sig_i), .cnt_clr_i(cnt_clr_i),
        .idex_ex_o(s_idex_ex), .idex_mem_o(s_idex_mem), .idex_wb_o(s_idex_wb),
        .idex_valid_o(s_idex_valid), .exmem_mem_o(s_exmem_mem),
        .exmem_wb_o(s_exmem_wb), .exmem_valid_o(s_exmem_valid),
        .memwb_wb_o(s_memwb_wb), .memwb_valid_o(s_memwb_valid),
        .bubble_cnt_o(s_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic v, input logic [1:0] ex, input logic [2:0] mem,
                         input logic [1:0] wb, input logic st, input logic fl,
                         input logic fz, input logic clr);
        @(negedge clk_i);
        valid_i = v; ex_sig_i = ex; mem_sig_i = mem; wb_sig_i = wb;
        stall_i = st; flush_i = fl; freeze_i = fz; cnt_clr_i = clr;
        if (v && !st && !fl && !fz) begin
            exp_ex_q.push_back(ex);
            exp_mem_q.push_back(mem);
            exp_wb_q.push_back(wb);
        end
    endtask

    task automatic idle();
        issue(1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic after_edge();
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    logic adv;
    initial begin
        forever begin
            @(posedge clk_i);
            adv = rst_i && !freeze_i;
            #1;
            if (adv) begin
                if (idex_valid_o) begin
                    if (exp_ex_q.size() == 0) chk("idex_unexpected", 1, 0);
                    else chk("idex_ex", idex_ex_o, exp_ex_q.pop_front());
                end else chk("idex_bubble_zero", {idex_ex_o, idex_mem_o, idex_wb_o}, 0);
                if (exmem_valid_o) begin
                    if (exp_mem_q.size() == 0) chk("exmem_unexpected", 1, 0);
                    else chk("exmem_mem", exmem_mem_o, exp_mem_q.pop_front());
                end else chk("exmem_bubble_zero", {exmem_mem_o, exmem_wb_o}, 0);
                if (memwb_valid_o) begin
                    if (exp_wb_q.size() == 0) chk("memwb_unexpected", 1, 0);
                    else chk("memwb_wb", memwb_wb_o, exp_wb_q.pop_front());
                end else chk("memwb_bubble_zero", memwb_wb_o, 0);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        #2;
        chk("reset_init", {idex_ex_o, idex_mem_o, idex_wb_o, idex_valid_o, exmem_mem_o,
            exmem_wb_o, exmem_valid_o, memwb_wb_o, memwb_valid_o, bubble_cnt_o}, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Fill the pipe and count one bubble, then reset mid-cycle.
        issue(1, 2'b01, 3'b001, 2'b01, 0, 0, 0, 0);
        issue(1, 2'b10, 3'b010, 2'b10, 0, 0, 0, 0);
        issue(1, 2'b11, 3'b011, 2'b11, 1, 0, 0, 0);
        issue(1, 2'b11, 3'b011, 2'b11, 0, 0, 0, 0);
        after_edge();
        chk("pre_reset_cnt", bubble_cnt_o, 1);
        @(negedge clk_i);
        valid_i = 1; ex_sig_i = 2'b10; mem_sig_i = 3'b101; wb_sig_i = 2'b11;
        stall_i = 0; flush_i = 0; freeze_i = 0; cnt_clr_i = 0;
        #1 rst_i = 1'b0;
        #1;
        chk("reset_async", {idex_ex_o, idex_mem_o, idex_wb_o, idex_valid_o, exmem_mem_o,
            exmem_wb_o, exmem_valid_o, memwb_wb_o, memwb_valid_o, bubble_cnt_o}, 0);
        chk("reset_async_sat", s_cnt, 0);
        exp_ex_q.delete(); exp_mem_q.delete(); exp_wb_q.delete();
        exp_ex_q.push_back(2'b10); exp_mem_q.push_back(3'b101); exp_wb_q.push_back(2'b11);
        #1 rst_i = 1'b1;
        after_edge();
        chk("lat1_idex", {idex_valid_o, idex_ex_o, idex_mem_o, idex_wb_o}, {1'b1, 2'b10, 3'b101, 2'b11});
        idle();
        after_edge();
        chk("lat2_exmem", {exmem_valid_o, exmem_mem_o}, {1'b1, 3'b101});
        idle();
        after_edge();
        chk("lat3_memwb", {memwb_valid_o, memwb_wb_o}, {1'b1, 2'b11});
        idle();

        // Load-use stall in a stream of distinct bundles.
        issue(1, 2'b01, 3'b001, 2'b01, 0, 0, 0, 0);
        issue(1, 2'b10, 3'b010, 2'b10, 0, 0, 0, 0);
        issue(1, 2'b11, 3'b011, 2'b11, 1, 0, 0, 0);
        after_edge();
        chk("stall_idex", {idex_valid_o, idex_ex_o}, 0);
        chk("stall_exmem_b", exmem_mem_o, 3'b010);
        issue(1, 2'b11, 3'b011, 2'b11, 0, 0, 0, 0);
        after_edge();
        chk("stall_held_capture", idex_ex_o, 2'b11);
        chk("stall_exmem_bubble", {exmem_valid_o, exmem_mem_o}, 0);
        issue(1, 2'b01, 3'b100, 2'b01, 0, 0, 0, 0);
        after_edge();
        chk("stall_memwb_bubble", {memwb_valid_o, memwb_wb_o}, 0);
        chk("stall_cnt", bubble_cnt_o, 1);
        repeat (3) idle();

        // Freeze with stall and flush asserted: nothing moves, nothing counted.
        issue(1, 2'b10, 3'b101, 2'b10, 0, 0, 0, 0);
        issue(1, 2'b11, 3'b110, 2'b11, 0, 0, 0, 0);
        issue(1, 2'b01, 3'b111, 2'b01, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            issue(1, 2'b10, 3'b011, 2'b01, 1, 1, 1, 0);
            after_edge();
            chk("freeze_hold", {idex_valid_o, idex_ex_o, exmem_valid_o, exmem_mem_o,
                memwb_valid_o, memwb_wb_o}, {1'b1, 2'b01, 1'b1, 3'b110, 1'b1, 2'b10});
            chk("freeze_cnt", bubble_cnt_o, 1);
        end
        issue(1, 2'b10, 3'b011, 2'b01, 0, 0, 0, 0);
        repeat (3) idle();

        // Stall and flush together count once; invalid input is not a bubble.
        issue(1, 2'b11, 3'b111, 2'b11, 1, 1, 0, 0);
        after_edge();
        chk("dual_hazard_cnt", bubble_cnt_o, 2);
        issue(0, 2'b11, 3'b111, 2'b11, 0, 0, 0, 0);
        after_edge();
        chk("invalid_idex", {idex_valid_o, idex_ex_o, idex_mem_o, idex_wb_o}, 0);
        chk("invalid_cnt", bubble_cnt_o, 2);

        // Saturation on the 2-bit counter instance.
        issue(0, 2'b00, 3'b000, 2'b00, 0, 0, 0, 1);
        after_edge();
        chk("clr_cnt", bubble_cnt_o, 0);
        chk("clr_sat", s_cnt, 0);
        for (int i = 1; i <= 5; i++) begin
            issue(0, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0);
            after_edge();
            chk("sat_cnt", s_cnt, (i > 3) ? 3 : i);
            chk("wide_cnt", bubble_cnt_o, i);
        end
        issue(0, 2'b00, 3'b000, 2'b00, 1, 0, 0, 1);
        after_edge();
        chk("clr_with_stall", {bubble_cnt_o, s_cnt}, 0);
        issue(0, 2'b00, 3'b000, 2'b00, 1, 0, 0, 0);
        after_edge();
        chk("cnt_after_clr", bubble_cnt_o, 1);
        issue(0, 2'b00, 3'b000, 2'b00, 0, 0, 1, 1);
        after_edge();
        chk("clr_over_freeze", {bubble_cnt_o, s_cnt}, 0);
        repeat (3) idle();
        after_edge();

        chk("drain_queues", exp_ex_q.size() + exp_mem_q.size() + exp_wb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
